// File: rtl/memory_block_server.sv
// memory_block_server: fixed-latency block store; ports: fetch/writeBack requests in, memBusy, fetchedData, fetchValid, writeBackDone out
module memory_block_server #(
  parameter int BLOCK_SIZE = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetchRequest,
  input  logic [ADDRESS_WIDTH-1:0]  fetchAddress,
  input  logic                      writeBackRequest,
  input  logic [ADDRESS_WIDTH-1:0]  writeBackAddress,
  input  logic [8*BLOCK_SIZE-1:0]   writeBackData,
  output logic                      memBusy,
  output logic [8*BLOCK_SIZE-1:0]   fetchedData,
  output logic                      fetchValid,
  output logic                      writeBackDone
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int IDX = $clog2(MEM_DEPTH);
  localparam int BW = 8 * BLOCK_SIZE;
  localparam int CW = ACCESS_LATENCY > 1 ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(ACCESS_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic fetchPending;
  logic [IDX-1:0] wbIdx, fIdx, wIdx, rIdx;
  logic [BW-1:0] wbData, wData;
  logic [BW-1:0] store [MEM_DEPTH];
  logic acceptWb, wbCommit, fCommit, unusedAddrBits;
  assign acceptWb = state == IDLE && writeBackRequest;
  assign wbCommit = ACCESS_LATENCY == 1 ? acceptWb : state == WRITEBACK && count == CW'(1);
  assign fCommit = ACCESS_LATENCY == 1
    ? (state == IDLE && !writeBackRequest && fetchRequest) || (state == WRITEBACK && fetchPending)
    : state == FETCH && count == CW'(1);
  assign wIdx = state == IDLE ? writeBackAddress[OFF +: IDX] : wbIdx;
  assign wData = state == IDLE ? writeBackData : wbData;
  assign rIdx = state == IDLE ? fetchAddress[OFF +: IDX] : fIdx;
  assign memBusy = state != IDLE;
  assign unusedAddrBits = ^{fetchAddress, writeBackAddress};
  always_ff @(posedge clk)
    if (!reset && wbCommit) store[wIdx] <= wData;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      fetchPending <= 1'b0;
      fetchValid <= 1'b0;
      writeBackDone <= 1'b0;
      fetchedData <= '0;
      wbIdx <= '0;
      fIdx <= '0;
      wbData <= '0;
    end else begin
      writeBackDone <= wbCommit;
      fetchValid <= fCommit;
      if (fCommit) fetchedData <= store[rIdx];
      case (state)
        IDLE: begin
          if (writeBackRequest) begin
            state <= WRITEBACK;
            count <= LOAD;
            wbIdx <= writeBackAddress[OFF +: IDX];
            wbData <= writeBackData;
            fIdx <= fetchAddress[OFF +: IDX];
            fetchPending <= fetchRequest;
          end else if (fetchRequest) begin
            state <= FETCH;
            count <= LOAD;
            fIdx <= fetchAddress[OFF +: IDX];
          end
        end
        WRITEBACK: begin
          if (count == '0) begin
            state <= fetchPending ? FETCH : IDLE;
            count <= LOAD;
            fetchPending <= 1'b0;
          end else count <= count - CW'(1);
        end
        FETCH: begin
          if (count == '0) state <= IDLE;
          else count <= count - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_block_server.sv
// tb_memory_block_server: directed checks of memory_block_server at latency 4 and latency 1
module tb_memory_block_server;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetchRequest = 1'b0, writeBackRequest = 1'b0;
  logic [31:0] fetchAddress = '0, writeBackAddress = '0;
  logic [255:0] writeBackData = '0, fetchedData;
  logic memBusy, fetchValid, writeBackDone;
  logic fetchRequest1 = 1'b0, writeBackRequest1 = 1'b0;
  logic [31:0] fetchAddress1 = '0, writeBackAddress1 = '0;
  logic [255:0] writeBackData1 = '0, fetchedData1;
  logic memBusy1, fetchValid1, writeBackDone1;
  int total = 0, bad = 0;
  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] P1234 = {16{16'h1234}};
  localparam logic [255:0] PD1 = {8{32'hDEADBEEF}};
  localparam logic [255:0] PD2 = {8{32'h5555AAAA}};
  localparam logic [255:0] PP = {8{32'h0BADF00D}};
  localparam logic [255:0] PQ = {8{32'hCAFEBABE}};
  always #5 clk = ~clk;
  memory_block_server dut (
    .clk(clk), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
    .writeBackRequest(writeBackRequest), .writeBackAddress(writeBackAddress),
    .writeBackData(writeBackData), .memBusy(memBusy), .fetchedData(fetchedData),
    .fetchValid(fetchValid), .writeBackDone(writeBackDone)
  );
  memory_block_server #(.ACCESS_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .fetchRequest(fetchRequest1), .fetchAddress(fetchAddress1),
    .writeBackRequest(writeBackRequest1), .writeBackAddress(writeBackAddress1),
    .writeBackData(writeBackData1), .memBusy(memBusy1), .fetchedData(fetchedData1),
    .fetchValid(fetchValid1), .writeBackDone(writeBackDone1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wbOnly(input logic [31:0] addr, input logic [255:0] data);
    writeBackRequest = 1'b1;
    writeBackAddress = addr;
    writeBackData = data;
    step();
    writeBackRequest = 1'b0;
    chk("wb_busy_T", memBusy, 1);
    chk("wb_done_T", writeBackDone, 0);
    step();
    step();
    chk("wb_done_T2", writeBackDone, 0);
    step();
    chk("wb_done_T3", writeBackDone, 1);
    chk("wb_busy_T3", memBusy, 1);
    step();
    chk("wb_done_T4", writeBackDone, 0);
    chk("wb_busy_T4", memBusy, 0);
  endtask
  task automatic fetchOnly(input logic [31:0] addr, input logic [255:0] exp);
    fetchRequest = 1'b1;
    fetchAddress = addr;
    step();
    fetchRequest = 1'b0;
    chk("f_busy_T", memBusy, 1);
    step();
    step();
    chk("f_valid_T2", fetchValid, 0);
    step();
    chk("f_valid_T3", fetchValid, 1);
    chk("f_data_T3", fetchedData, exp);
    step();
    chk("f_valid_T4", fetchValid, 0);
    chk("f_busy_T4", memBusy, 0);
    chk("f_data_hold", fetchedData, exp);
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", memBusy, 0);
    chk("rst_valid", fetchValid, 0);
    chk("rst_done", writeBackDone, 0);
    chk("rst_data", fetchedData, 0);
    chk("rst_busy1", memBusy1, 0);
    wbOnly(32'h0000_0040, PA5);
    fetchOnly(32'h0000_0040, PA5);
    writeBackRequest = 1'b1;
    fetchRequest = 1'b1;
    writeBackAddress = 32'h100;
    fetchAddress = 32'h100;
    writeBackData = P1234;
    step();
    writeBackRequest = 1'b0;
    fetchRequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("comb_busy", memBusy, 1);
      chk("comb_done", writeBackDone, k == 3);
      chk("comb_valid", fetchValid, k == 7);
      if (k == 7) chk("comb_data", fetchedData, P1234);
      step();
    end
    chk("comb_busy_end", memBusy, 0);
    chk("comb_valid_end", fetchValid, 0);
    wbOnly(32'h0000_0020, PD1);
    fetchOnly(32'h0000_003C, PD1);
    fetchOnly(32'h0000_2020, PD1);
    writeBackRequest = 1'b1;
    writeBackAddress = 32'h60;
    writeBackData = PD2;
    step();
    writeBackRequest = 1'b0;
    step();
    fetchRequest = 1'b1;
    fetchAddress = 32'h60;
    step();
    fetchRequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("busy_req_valid", fetchValid, 0);
      chk("busy_req_busy", memBusy, k < 2);
      step();
    end
    wbOnly(32'h0000_0080, PP);
    writeBackRequest = 1'b1;
    writeBackAddress = 32'h80;
    writeBackData = PQ;
    step();
    writeBackRequest = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_done", writeBackDone, 0);
    chk("abort_busy", memBusy, 0);
    chk("abort_valid", fetchValid, 0);
    chk("abort_data", fetchedData, 0);
    step();
    chk("abort_done2", writeBackDone, 0);
    fetchOnly(32'h0000_0080, PP);
    writeBackRequest1 = 1'b1;
    writeBackAddress1 = 32'h40;
    writeBackData1 = PD1;
    step();
    writeBackRequest1 = 1'b0;
    chk("l1_wb_done", writeBackDone1, 1);
    chk("l1_wb_busy", memBusy1, 1);
    step();
    chk("l1_wb_done_end", writeBackDone1, 0);
    chk("l1_wb_busy_end", memBusy1, 0);
    fetchRequest1 = 1'b1;
    fetchAddress1 = 32'h40;
    step();
    fetchRequest1 = 1'b0;
    chk("l1_f_valid", fetchValid1, 1);
    chk("l1_f_data", fetchedData1, PD1);
    chk("l1_f_busy", memBusy1, 1);
    step();
    chk("l1_f_valid_end", fetchValid1, 0);
    chk("l1_f_busy_end", memBusy1, 0);
    chk("l1_f_data_hold", fetchedData1, PD1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_block_server.md
# memory_block_server

Main-memory-side stage for the cache controller. It consumes the controller's memory-facing signals: block fetch address, write-back address and write-back data. It services each request after a fixed access latency and returns fetched blocks. It holds a block-organised backing store and orders a dirty-victim write-back ahead of the refill fetch that accompanies it.

## Interface
Parameters:
- BLOCK_SIZE, 32, block size in bytes; power of two, ≥4
- ADDRESS_WIDTH, 32, byte-address width
- MEM_DEPTH, 256, number of blocks in the backing store; power of two
- ACCESS_LATENCY, 4, cycles from request acceptance to completion; ≥1

Ports:
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- fetchRequest  input  1  controller requests a block read
- fetchAddress  input  ADDRESS_WIDTH  byte address of block to read
- writeBackRequest  input  1  controller requests a block write
- writeBackAddress  input  ADDRESS_WIDTH  byte address of block to write
- writeBackData  input  8*BLOCK_SIZE  block data to write
- memBusy  output  1  high while a request is in service; requests are not accepted
- fetchedData  output  8*BLOCK_SIZE  block read result; holds its value until the next fetch completes
- fetchValid  output  1  one-cycle pulse: fetchedData updated this cycle
- writeBackDone  output  1  one-cycle pulse: write committed to the store

## Operation
- Block index = address[OFF +: IDX], with OFF = $clog2(BLOCK_SIZE) and IDX = $clog2(MEM_DEPTH).
  - Low OFF bits are ignored.
  - Bits above OFF+IDX are ignored, so addresses alias modulo MEM_DEPTH blocks.
- Backing store is not cleared by reset. Contents are undefined until written.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, memBusy=0:
  - writeBackRequest=1 → latch index and data, go to WRITEBACK. If fetchRequest=1 in the same cycle, latch the fetch index and set fetchPending.
  - else fetchRequest=1 → latch index, go to FETCH.
  - Requests are sampled only in IDLE. The requester may deassert a request after the acceptance edge.
- WRITEBACK:
  - The latency counter counts down from ACCESS_LATENCY-1.
  - At 0: write latched data to the store, pulse writeBackDone.
  - Next state is FETCH (with the counter reloaded) if fetchPending, else IDLE.
- FETCH:
  - The latency counter counts down from ACCESS_LATENCY-1.
  - At 0: load fetchedData from the store and pulse fetchValid.
  - Next state is IDLE.
- Simultaneous write-back and fetch to the same block: the fetch returns the newly written data.
- memBusy = (state != IDLE). Requests seen while memBusy=1 are ignored and not queued.
- Latency counter width is $clog2(ACCESS_LATENCY). With ACCESS_LATENCY=1 the counter is omitted or held at 0.

## Timing
- Reset values:
  - state=IDLE, memBusy=0, fetchValid=0, writeBackDone=0, fetchedData=0, fetchPending=0, counter=0.
- Acceptance edge is T, meaning the request is high in IDLE during cycle T-1.
  - memBusy is high from cycle T.
  - The completion pulse is high in cycle T+ACCESS_LATENCY-1.
  - For a single request, memBusy falls in cycle T+ACCESS_LATENCY and a new request can be accepted at that cycle's edge.
- Combined write-back plus fetch:
  - writeBackDone is high in cycle T+L-1 and fetchValid in cycle T+2L-1, where L = ACCESS_LATENCY.
  - memBusy stays high continuously through both.
- fetchedData changes only in the cycle fetchValid is high, and is stable otherwise.
- Reset asserted mid-operation aborts the request in progress:
  - no store write and no completion pulse;
  - all outputs go to their reset values on the next edge.

## Test plan
- Write-back then fetch to the same block:
  - Write-back to 0x0000_0040 with data pattern A5 repeated; writeBackDone pulses 4 cycles after acceptance.
  - Fetch from 0x0000_0040; fetchValid pulses 4 cycles later with fetchedData = pattern A5.
- Same-cycle fetch and write-back to 0x100 with data 0x1234…:
  - writeBackDone at T+3, fetchValid at T+7.
  - fetchedData = 0x1234…; memBusy is never low between the two pulses.
- Offset and aliasing:
  - Write-back to 0x0000_0020, then fetch from 0x0000_003C: fetch returns the same data (offset ignored).
  - Fetch from 0x0000_2020 (same index with MEM_DEPTH=256): also returns the same data.
- Request while busy: fetchRequest pulsed for one cycle while memBusy=1 → no fetchValid follows, state returns to IDLE.
- Reset mid-write-back: reset asserted 2 cycles after acceptance.
  - No writeBackDone; all outputs are 0 the next cycle.
  - A subsequent fetch of that block does not return the aborted data, given the block was preloaded with a known prior value.
- ACCESS_LATENCY=1 variant: fetch accepted at T → fetchValid in cycle T, memBusy high for one cycle only.
